// File: rtl/bitfuscnn_pkg.sv
// Shared types and helpers for the accumulator drain path.
// - drain_state_t  : drain sequencer FSM states
// - EXCH_ALL       : neighbor-exchange mask value meaning all 8 halos are in
// - active_entries : entries per bank that hold data for a given bitwidth mode
package bitfuscnn_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_EXCH = 3'd1,
        DRAIN     = 3'd2,
        FLUSH     = 3'd3,
        DONE      = 3'd4
    } drain_state_t;

    localparam logic [7:0] EXCH_ALL = 8'hFF;

    // Narrower operands pack more values per entry, so fewer entries are live.
    function automatic int unsigned active_entries(input logic [1:0] bitwidth,
                                                   input int unsigned tile_size);
        case (bitwidth)
            2'b00:   active_entries = tile_size;
            2'b01:   active_entries = tile_size >> 1;
            default: active_entries = tile_size >> 2;
        endcase
    endfunction

endpackage

// File: rtl/zero_run_encoder.sv
// Zero-run compressor for the drain stream.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   clear             restart the run count (new drain)
//   valid, v          returned accumulator byte and its qualifier
//   wr, value, index  combinational write request: byte plus zeros skipped before it
// A run that saturates the index field is emitted as a zero-valued entry so the
// decoder never loses count; zeros left over at the end are simply never written.
module zero_run_encoder
    import bitfuscnn_pkg::*;
#(
    parameter int INDEX_WIDTH = 4,
    parameter bit RELU_EN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   valid,
    input  logic [7:0]             v,
    output logic                   wr,
    output logic [7:0]             value,
    output logic [INDEX_WIDTH-1:0] index
);

    localparam logic [INDEX_WIDTH-1:0] RUN_MAX = '1;

    logic [INDEX_WIDTH-1:0] run_q, run_d;
    logic [7:0]             v_s;

    // ReLU: a set sign bit means a negative partial sum, drained as zero.
    always_comb begin
        if (RELU_EN && v[7]) begin
            v_s = 8'h00;
        end else begin
            v_s = v;
        end
    end

    // Run-length decision and next run count.
    always_comb begin
        wr    = 1'b0;
        value = 8'h00;
        index = '0;
        run_d = run_q;
        if (clear) begin
            run_d = '0;
        end else if (valid) begin
            if (v_s != 8'h00) begin
                wr    = 1'b1;
                value = v_s;
                index = run_q;
                run_d = '0;
            end else if (run_q == RUN_MAX) begin
                wr    = 1'b1;
                value = 8'h00;
                index = run_q;
                run_d = '0;
            end else begin
                run_d = run_q + INDEX_WIDTH'(1);
            end
        end else begin
            run_d = run_q;
        end
    end

    // Run counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/accumulator_drain_sequencer.sv
// Drains the PPU accumulator buffer into OARAM at the end of a channel group.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   channel_group_done       start pulse (honoured only when idle)
//   bitwidth                 entries/bank mode, captured at start
//   neighbor_exchange_done   per-neighbor halo done, pulse or level
//   buffer_bank_read/entry   buffer read address (0 outside the sweep)
//   buffer_data_read         read data, one cycle after the address
//   oaram_value/indices_value/address/write_enable  registered OARAM write
//   busy, cycle_done         activity flag and one-cycle completion pulse
//   overflow                 sticky until next start: writes past the top of OARAM dropped
// Read address at t, data at t+1, registered OARAM write at t+2; the two FLUSH
// cycles cover exactly that latency before cycle_done.
module accumulator_drain_sequencer
    import bitfuscnn_pkg::*;
#(
    parameter int RAM_WIDTH   = 10,
    parameter int BANK_COUNT  = 32,
    parameter int TILE_SIZE   = 128,
    parameter int INDEX_WIDTH = 4,
    parameter bit RELU_EN     = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          channel_group_done,
    input  logic [1:0]                    bitwidth,
    input  logic [7:0]                    neighbor_exchange_done,
    output logic [$clog2(BANK_COUNT)-1:0] buffer_bank_read,
    output logic [$clog2(TILE_SIZE)-1:0]  buffer_bank_entry,
    input  logic [7:0]                    buffer_data_read,
    output logic [7:0]                    oaram_value,
    output logic [INDEX_WIDTH-1:0]        oaram_indices_value,
    output logic [RAM_WIDTH-2:0]          oaram_address,
    output logic                          oaram_write_enable,
    output logic                          busy,
    output logic                          cycle_done,
    output logic                          overflow
);

    localparam int BANK_W  = $clog2(BANK_COUNT);
    localparam int ENTRY_W = $clog2(TILE_SIZE);
    localparam int ADDR_W  = RAM_WIDTH - 1;
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(BANK_COUNT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    drain_state_t state_q, state_d;
    logic [7:0]         mask_q, mask_d, exch_seen_s;
    logic [1:0]         bw_q, bw_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic [ENTRY_W-1:0] entry_q, entry_d, last_entry_s;
    logic               flush_q, flush_d;
    logic               rd_valid_q;
    logic [ADDR_W-1:0]  waddr_q, waddr_d, oaddr_q, oaddr_d;
    logic               full_q, full_d, ovf_q, ovf_d;
    logic               we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]         val_q, val_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic               start_s, enc_wr_s;
    logic [7:0]         enc_value_s;
    logic [INDEX_WIDTH-1:0] enc_index_s;

    // Start qualification, accumulated exchange mask and sweep end point.
    always_comb begin
        start_s      = (state_q == IDLE) && channel_group_done;
        exch_seen_s  = mask_q | neighbor_exchange_done;
        last_entry_s = ENTRY_W'(active_entries(bw_q, TILE_SIZE) - 1);
    end

    zero_run_encoder #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .RELU_EN     (RELU_EN)
    ) u_enc (
        .clk   (clk),
        .reset (reset),
        .clear (start_s),
        .valid (rd_valid_q),
        .v     (buffer_data_read),
        .wr    (enc_wr_s),
        .value (enc_value_s),
        .index (enc_index_s)
    );

    // FSM next state, exchange mask and bank-inner/entry-outer sweep counters.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        bw_d    = bw_q;
        bank_d  = bank_q;
        entry_d = entry_q;
        flush_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = WAIT_EXCH;
                    mask_d  = neighbor_exchange_done;
                    bw_d    = bitwidth;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_EXCH: begin
                mask_d = exch_seen_s;
                if (exch_seen_s == EXCH_ALL) begin
                    state_d = DRAIN;
                end else begin
                    state_d = WAIT_EXCH;
                end
            end
            DRAIN: begin
                if (bank_q == BANK_LAST) begin
                    bank_d = '0;
                    if (entry_q == last_entry_s) begin
                        entry_d = '0;
                        state_d = FLUSH;
                    end else begin
                        entry_d = entry_q + ENTRY_W'(1);
                    end
                end else begin
                    bank_d = bank_q + BANK_W'(1);
                end
            end
            FLUSH: begin
                flush_d = ~flush_q;
                if (flush_q) begin
                    state_d = DONE;
                end else begin
                    state_d = FLUSH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // OARAM write stage: the write at the last address lands, later ones only flag overflow.
    always_comb begin
        we_d    = 1'b0;
        val_d   = 8'h00;
        idx_d   = '0;
        oaddr_d = '0;
        waddr_d = waddr_q;
        full_d  = full_q;
        ovf_d   = ovf_q;
        if (start_s) begin
            waddr_d = '0;
            full_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (enc_wr_s) begin
            if (full_q) begin
                ovf_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                val_d   = enc_value_s;
                idx_d   = enc_index_s;
                oaddr_d = waddr_q;
                if (waddr_q == ADDR_LAST) begin
                    full_d = 1'b1;
                end else begin
                    waddr_d = waddr_q + ADDR_W'(1);
                end
            end
        end else begin
            ovf_d = ovf_q;
        end
        busy_d = (state_d == WAIT_EXCH) || (state_d == DRAIN) || (state_d == FLUSH);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mask_q     <= 8'h00;
            bw_q       <= 2'b00;
            bank_q     <= '0;
            entry_q    <= '0;
            flush_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            waddr_q    <= '0;
            oaddr_q    <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            we_q       <= 1'b0;
            val_q      <= 8'h00;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            bw_q       <= bw_d;
            bank_q     <= bank_d;
            entry_q    <= entry_d;
            flush_q    <= flush_d;
            rd_valid_q <= (state_q == DRAIN);
            waddr_q    <= waddr_d;
            oaddr_q    <= oaddr_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            we_q       <= we_d;
            val_q      <= val_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign buffer_bank_read    = bank_q;
    assign buffer_bank_entry   = entry_q;
    assign oaram_value         = val_q;
    assign oaram_indices_value = idx_q;
    assign oaram_address       = oaddr_q;
    assign oaram_write_enable  = we_q;
    assign busy                = busy_q;
    assign cycle_done          = done_q;
    assign overflow            = ovf_q;

endmodule

// File: tb/tb_accumulator_drain_sequencer.sv
// Bench: two sequencers (ReLU on / off) share stimulus; each has its own buffer
// model. Expected writes come from a list-based model of the compression rules.
module tb_accumulator_drain_sequencer;

    localparam int BANKS = 4;
    localparam int TILE  = 8;
    localparam int IW    = 4;
    localparam int RW    = 10;
    localparam int AW    = RW - 1;
    localparam int CAP   = 1 << AW;
    localparam int RMAX  = (1 << IW) - 1;

    logic clk = 1'b0;
    logic reset, cgd;
    logic [1:0] bitwidth;
    logic [7:0] ned;
    logic [1:0] bank_r, bank_n;
    logic [2:0] entry_r, entry_n;
    logic [7:0] rdata_r, rdata_n, val_r, val_n;
    logic [IW-1:0] idx_r, idx_n;
    logic [AW-1:0] addr_r, addr_n;
    logic we_r, we_n, busy_r, busy_n, done_r, done_n, ovf_r, ovf_n;

    logic [7:0] mem [BANKS][TILE];
    int cyc = 0;
    int c0 = 0;
    int n_cmp = 0;
    int n_mis = 0;
    logic [63:0] obs_r[$], obs_n[$], exp_r[$], exp_n[$];

    accumulator_drain_sequencer #(.RAM_WIDTH(RW), .BANK_COUNT(BANKS), .TILE_SIZE(TILE),
                                  .INDEX_WIDTH(IW), .RELU_EN(1'b1)) dut_r (
        .clk(clk), .reset(reset), .channel_group_done(cgd), .bitwidth(bitwidth),
        .neighbor_exchange_done(ned), .buffer_bank_read(bank_r), .buffer_bank_entry(entry_r),
        .buffer_data_read(rdata_r), .oaram_value(val_r), .oaram_indices_value(idx_r),
        .oaram_address(addr_r), .oaram_write_enable(we_r), .busy(busy_r),
        .cycle_done(done_r), .overflow(ovf_r));

    accumulator_drain_sequencer #(.RAM_WIDTH(RW), .BANK_COUNT(BANKS), .TILE_SIZE(TILE),
                                  .INDEX_WIDTH(IW), .RELU_EN(1'b0)) dut_n (
        .clk(clk), .reset(reset), .channel_group_done(cgd), .bitwidth(bitwidth),
        .neighbor_exchange_done(ned), .buffer_bank_read(bank_n), .buffer_bank_entry(entry_n),
        .buffer_data_read(rdata_n), .oaram_value(val_n), .oaram_indices_value(idx_n),
        .oaram_address(addr_n), .oaram_write_enable(we_n), .busy(busy_n),
        .cycle_done(done_n), .overflow(ovf_n));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous buffer: data one cycle after the address.
    always @(posedge clk) begin
        rdata_r <= mem[bank_r][entry_r];
        rdata_n <= mem[bank_n][entry_n];
    end

    function automatic logic [63:0] pack(input logic [7:0] v, input logic [3:0] i,
                                         input int a, input int r);
        logic [15:0] a16, r16;
        a16 = a[15:0];
        r16 = r[15:0];
        return {16'h0000, r16, a16, v, 4'h0, i};
    endfunction

    // Write capture, time-stamped relative to the start edge.
    always @(negedge clk) begin
        if (we_r === 1'b1) obs_r.push_back(pack(val_r, idx_r, int'(addr_r), cyc - c0));
        if (we_n === 1'b1) obs_n.push_back(pack(val_n, idx_n, int'(addr_n), cyc - c0));
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk entries/banks in drain order, apply the zero-run rules,
    // and place each write at base+n, stamped w+k+1 for read number k.
    task automatic model(input bit relu, input logic [1:0] bw, input int base,
                         input int w, output bit ovf);
        int ents, run, k, n, ei;
        logic [7:0] v, ev;
        bit emit;
        ents = (bw == 2'b00) ? TILE : ((bw == 2'b01) ? TILE / 2 : TILE / 4);
        run = 0; k = 0; n = 0; ovf = 1'b0; ei = 0; ev = 8'h00;
        for (int e = 0; e < ents; e++) begin
            for (int b = 0; b < BANKS; b++) begin
                k++;
                v = mem[b][e];
                if (relu && v[7]) v = 8'h00;
                emit = 1'b0;
                if (v != 8'h00) begin
                    emit = 1'b1; ev = v; ei = run; run = 0;
                end else if (run == RMAX) begin
                    emit = 1'b1; ev = 8'h00; ei = run; run = 0;
                end else begin
                    run++;
                end
                if (emit) begin
                    if (base + n < CAP) begin
                        if (relu) exp_r.push_back(pack(ev, ei[3:0], base + n, w + k + 1));
                        else      exp_n.push_back(pack(ev, ei[3:0], base + n, w + k + 1));
                        n++;
                    end else begin
                        ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    // One full drain; caller is at a negedge with the DUTs idle.
    task automatic run_drain(input logic [1:0] bw, input bit pulse, input bit force_full,
                             input string tag);
        logic [7:0] ned_win [64];
        int w, n_reads, last, k, eb, ee, off, rot;
        bit ovf_re, ovf_ne;
        n_reads = BANKS * ((bw == 2'b00) ? TILE : ((bw == 2'b01) ? TILE / 2 : TILE / 4));
        for (int i = 0; i < 64; i++) ned_win[i] = pulse ? 8'h00 : 8'hFF;
        if (pulse) begin
            w = 20;
            off = $urandom_range(0, 12);
            rot = $urandom_range(0, 6);
            for (int i = 0; i < 7; i++) ned_win[off + i] = 8'h01 << ((i + rot) % 7);
            ned_win[20] = 8'h80;
        end else begin
            w = 1;
        end
        last = w + n_reads + 3;
        obs_r.delete(); obs_n.delete(); exp_r.delete(); exp_n.delete();
        model(1'b1, bw, force_full ? CAP - 1 : 0, w, ovf_re);
        model(1'b0, bw, force_full ? CAP - 1 : 0, w, ovf_ne);
        cgd = 1'b1; bitwidth = bw; ned = ned_win[0];
        @(negedge clk);
        c0 = cyc;
        for (int r = 0; r <= last; r++) begin
            k = r - w + 1;
            if (k >= 1 && k <= n_reads) begin
                eb = (k - 1) % BANKS; ee = (k - 1) / BANKS;
            end else begin
                eb = 0; ee = 0;
            end
            chk_eq({tag, "/bank_r"},  64'(bank_r),  64'(eb));
            chk_eq({tag, "/entry_r"}, 64'(entry_r), 64'(ee));
            chk_eq({tag, "/bank_n"},  64'(bank_n),  64'(eb));
            chk_eq({tag, "/entry_n"}, 64'(entry_n), 64'(ee));
            chk_eq({tag, "/busy"},    64'({busy_r, busy_n}), 64'({2{r <= w + n_reads + 1}}));
            chk_eq({tag, "/done"},    64'({done_r, done_n}), 64'({2{r == w + n_reads + 2}}));
            if (r == 0) chk_eq({tag, "/ovf_clr"}, 64'({ovf_r, ovf_n}), 64'(0));
            if (force_full && r == 3) begin
                force dut_r.waddr_q = 9'h1FF;
                force dut_n.waddr_q = 9'h1FF;
            end
            if (force_full && r == 5) begin
                release dut_r.waddr_q;
                release dut_n.waddr_q;
            end
            ned      = (r + 1 <= w) ? ned_win[r + 1] : 8'($urandom);
            cgd      = (r + 1 <= last) ? ($urandom_range(0, 5) == 0) : 1'b0;
            bitwidth = 2'($urandom);
            @(negedge clk);
        end
        cgd = 1'b0;
        chk_eq({tag, "/nwr_r"}, 64'(obs_r.size()), 64'(exp_r.size()));
        for (int i = 0; i < exp_r.size() && i < obs_r.size(); i++)
            chk_eq({tag, "/wr_r"}, obs_r[i], exp_r[i]);
        chk_eq({tag, "/nwr_n"}, 64'(obs_n.size()), 64'(exp_n.size()));
        for (int i = 0; i < exp_n.size() && i < obs_n.size(); i++)
            chk_eq({tag, "/wr_n"}, obs_n[i], exp_n[i]);
        chk_eq({tag, "/ovf_r"}, 64'(ovf_r), 64'(ovf_re));
        chk_eq({tag, "/ovf_n"}, 64'(ovf_n), 64'(ovf_ne));
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int b = 0; b < BANKS; b++)
            for (int e = 0; e < TILE; e++) mem[b][e] = v;
    endtask

    task automatic fill_sparse();
        for (int b = 0; b < BANKS; b++)
            for (int e = 0; e < TILE; e++)
                mem[b][e] = ($urandom_range(0, 9) < 6) ? 8'h00 : 8'($urandom);
    endtask

    function automatic logic [63:0] outs_r();
        return 64'({bank_r, entry_r, val_r, idx_r, addr_r, we_r, busy_r, done_r, ovf_r});
    endfunction

    function automatic logic [63:0] outs_n();
        return 64'({bank_n, entry_n, val_n, idx_n, addr_n, we_n, busy_n, done_n, ovf_n});
    endfunction

    // Reset in the middle of a sweep; then nothing may complete.
    task automatic reset_mid_drain();
        fill_const(8'h11);
        cgd = 1'b1; bitwidth = 2'b00; ned = 8'hFF;
        @(negedge clk);
        cgd = 1'b0;
        repeat (6) @(negedge clk);
        chk_eq("midrst/busy_before", 64'({busy_r, busy_n}), 64'(3));
        reset = 1'b1;
        #1;
        chk_eq("midrst/outs_r", outs_r(), 64'(0));
        chk_eq("midrst/outs_n", outs_n(), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_eq("midrst/quiet", 64'({done_r, done_n, busy_r, busy_n, we_r, we_n}), 64'(0));
        end
    endtask

    initial begin
        reset = 1'b1; cgd = 1'b0; bitwidth = 2'b00; ned = 8'h00;
        fill_const(8'h00);
        @(negedge clk);
        @(negedge clk);
        chk_eq("reset/outs_r", outs_r(), 64'(0));
        chk_eq("reset/outs_n", outs_n(), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        chk_eq("idle/outs_r", outs_r(), 64'(0));

        // All zeros: two full-run placeholders.
        run_drain(2'b00, 1'b0, 1'b0, "zeros");
        chk_eq("zeros/count", 64'(obs_r.size()), 64'(2));
        chk_eq("zeros/w0", (obs_r.size() > 0) ? obs_r[0] : '1, pack(8'h00, 4'hF, 0, 18));
        chk_eq("zeros/w1", (obs_r.size() > 1) ? obs_r[1] : '1, pack(8'h00, 4'hF, 1, 34));

        // Staggered exchange pulses; first read only after neighbor 7.
        fill_sparse();
        mem[0][0] = 8'h33;
        run_drain(2'b00, 1'b1, 1'b0, "pulse");
        chk_eq("pulse/first", (obs_r.size() > 0) ? obs_r[0] : '1, pack(8'h33, 4'h0, 0, 22));

        // Hand-placed values around a negative.
        fill_const(8'h00);
        mem[2][0] = 8'h05; mem[0][1] = 8'h80; mem[1][1] = 8'h7F;
        run_drain(2'b00, 1'b0, 1'b0, "relu");
        chk_eq("relu/w0",  (obs_r.size() > 0) ? obs_r[0] : '1, pack(8'h05, 4'h2, 0, 5));
        chk_eq("relu/w1",  (obs_r.size() > 1) ? obs_r[1] : '1, pack(8'h7F, 4'h2, 1, 8));
        chk_eq("norelu/w1", (obs_n.size() > 1) ? obs_n[1] : '1, pack(8'h80, 4'h1, 1, 7));
        chk_eq("norelu/w2", (obs_n.size() > 2) ? obs_n[2] : '1, pack(8'h7F, 4'h0, 2, 8));

        // Quarter tile, dense data.
        fill_const(8'h01);
        run_drain(2'b10, 1'b0, 1'b0, "bw10");
        chk_eq("bw10/count", 64'(obs_r.size()), 64'(8));

        // Address-full boundary.
        run_drain(2'b10, 1'b1, 1'b1, "full");
        chk_eq("full/count", 64'(obs_r.size()), 64'(1));
        chk_eq("full/w0", (obs_r.size() > 0) ? obs_r[0] : '1, pack(8'h01, 4'h0, 511, 22));
        chk_eq("full/ovf", 64'(ovf_r), 64'(1));

        // Next start clears overflow (checked at its first cycle).
        fill_sparse();
        run_drain(2'b11, 1'b0, 1'b0, "after_full");

        reset_mid_drain();
        fill_sparse();
        run_drain(2'b00, 1'b0, 1'b0, "restart");

        for (int i = 0; i < 5; i++) begin
            fill_sparse();
            run_drain(2'($urandom), 1'($urandom), 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
